// File: rtl/pwm_audio_sched.sv
// Sample scheduler for the 12-bit PWM audio generator: buffers signed PCM,
// primes, then pops one sample per PWM period with volume/mute applied.
module pwm_audio_sched #(
  parameter int PERIOD      = 4536,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                        clk_200mhz,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [15:0]                 s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [2:0]                  vol,
  input  logic                        mute,
  output logic [11:0]                 pwm_din,
  output logic                        sample_tick,
  output logic                        playing,
  output logic [15:0]                 underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(PERIOD);

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

  state_t         state;
  logic [CW-1:0]  counter;
  logic [15:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           flush;
  logic           push;
  logic           pop;
  logic [11:0]    shifted;
  logic [11:0]    conv;

  // Disabling in PLAY empties the FIFO on the tick edge; block pushes then.
  assign flush   = sample_tick & (state == PLAY) & ~enable;
  assign s_ready = ~rst & (fifo_level < LW'(FIFO_DEPTH)) & ~flush;
  assign push    = s_valid & s_ready;

  always_comb begin
    pop = 1'b0;
    if (sample_tick && enable && fifo_level != '0) begin
      if (state == PLAY)
        pop = 1'b1;
      else if (state == PRIME && fifo_level >= LW'(PRIME_LEVEL))
        pop = 1'b1;
    end
  end

  // Shifting by vol+4 and keeping 12 bits yields (x >>> vol)[15:4] directly.
  assign shifted = 12'($signed(mem[rd_ptr]) >>> ({1'b0, vol} + 4'd4));
  assign conv    = mute ? 12'h800 : {~shifted[11], shifted[10:0]};

  always_ff @(posedge clk_200mhz or posedge rst) begin
    if (rst) begin
      counter     <= '0;
      sample_tick <= 1'b0;
    end else begin
      counter     <= (counter == CW'(PERIOD - 1)) ? '0 : counter + 1'b1;
      sample_tick <= (counter == CW'(PERIOD - 2));
    end
  end

  always_ff @(posedge clk_200mhz) begin
    if (push)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk_200mhz or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk_200mhz or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pwm_din      <= 12'h800;
      playing      <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable)
            state <= PRIME;
        end
        PRIME: begin
          if (!enable) begin
            state <= IDLE;
          end else if (pop) begin
            state   <= PLAY;
            playing <= 1'b1;
            pwm_din <= conv;
          end
        end
        PLAY: begin
          if (sample_tick) begin
            if (!enable) begin
              state   <= IDLE;
              playing <= 1'b0;
              pwm_din <= 12'h800;
            end else if (pop) begin
              pwm_din <= conv;
            end else begin
              state   <= PRIME;
              playing <= 1'b0;
              pwm_din <= 12'h800;
              if (underrun_cnt != '1)
                underrun_cnt <= underrun_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
